// File: rtl/hc_pipelined_subtractor_pkg.sv
// Shared arithmetic package for the Han-Carlson adder/subtractor family:
// generate/propagate pair type and the prefix black-cell operator.
package hc_arith_pkg;

    // Default operand width of the datapath family
    localparam int unsigned HC_WIDTH  = 16;
    // Number of prefix levels in the even-bit tree
    localparam int unsigned HC_LEVELS = $clog2(HC_WIDTH);

    // Generate / propagate pair for one bit or one bit group
    typedef struct packed {
        logic g;
        logic p;
    } pg_t;

    // Black-cell operator: merges a higher group with the adjacent lower group
    function automatic pg_t pg_combine(pg_t hi, pg_t lo);
        pg_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/hc_pipelined_subtractor_if.sv
// Operand/result handshake bundle for the pipelined subtractor.
// master = producer/consumer side, slave = the subtractor itself.
interface hc_pipelined_subtractor_if #(
    parameter int unsigned WIDTH = 16
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf, zero
    );

endinterface

// File: rtl/hc_pipelined_subtractor_prefix_cell.sv
// Han-Carlson black cell: one prefix merge of two adjacent g/p groups.
module hc_prefix_cell
    import hc_arith_pkg::*;
(
    input  pg_t hi,
    input  pg_t lo,
    output pg_t grp
);

    assign grp = pg_combine(hi, lo);

endmodule

// File: rtl/hc_pipelined_subtractor.sv
// Three-stage elastic subtractor: diff = a - b - bin computed as a + ~b + ~bin
// through a Han-Carlson prefix network.
//   S0: operand registers, bitwise g/p
//   S1: even-bit prefix tree result registered
//   S2: odd-bit fix-up, sum and flags registered as the outputs
module hc_pipelined_subtractor
    import hc_arith_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    hc_pipelined_subtractor_if.slave bus
);

    localparam int unsigned LEVELS = $clog2(WIDTH);

    // ------------------------------------------------------------------
    // Stage state
    // ------------------------------------------------------------------
    logic             s0_valid;
    logic             s1_valid;
    logic             s2_valid;
    logic             s0_ready;
    logic             s1_ready;
    logic             s2_ready;

    logic [WIDTH-1:0] s0_a;
    logic [WIDTH-1:0] s0_nb;
    logic             s0_cin;

    pg_t              s1_grp [WIDTH];
    logic [WIDTH-1:0] s1_p;
    logic             s1_cin;
    logic             s1_a_msb;
    logic             s1_b_msb;

    logic [WIDTH-1:0] out_diff;
    logic             out_bout;
    logic             out_ovf;
    logic             out_zero;

    // ------------------------------------------------------------------
    // Combinational datapath signals
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] s0_p;
    pg_t              bit_pg   [WIDTH];
    pg_t              tree_out [WIDTH];
    pg_t              s2_full  [WIDTH];
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             next_bout;
    logic             next_ovf;
    logic             next_zero;
    logic             fixup_p_unused;

    // ------------------------------------------------------------------
    // Handshake control
    // ------------------------------------------------------------------

    // A stage can take new contents when empty or when its occupant leaves this cycle
    always_comb begin
        s2_ready = !s2_valid || bus.out_ready;
        s1_ready = !s1_valid || s2_ready;
        s0_ready = !s0_valid || s1_ready;
    end

    assign bus.in_ready  = !rst && s0_ready;
    assign bus.out_valid = s2_valid;
    assign bus.diff      = out_diff;
    assign bus.bout      = out_bout;
    assign bus.ovf       = out_ovf;
    assign bus.zero      = out_zero;

    // Valid bits advance through the pipe; reset discards everything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid <= 1'b0;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s0_ready) s0_valid <= bus.in_valid;
            if (s1_ready) s1_valid <= s0_valid;
            if (s2_ready) s2_valid <= s1_valid;
        end
    end

    // ------------------------------------------------------------------
    // S0: operand capture (subtrahend inverted, borrow turned into carry)
    // ------------------------------------------------------------------

    // Operand registers load on accept; no reset needed, qualified by s0_valid
    always_ff @(posedge clk) begin
        if (s0_ready && bus.in_valid) begin
            s0_a   <= bus.a;
            s0_nb  <= ~bus.b;
            s0_cin <= ~bus.bin;
        end
    end

    assign s0_p = s0_a ^ s0_nb;

    // Bitwise g/p; carry-in folded into bit 0 so the tree needs no extra column
    always_comb begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
            bit_pg[i].g = s0_a[i] & s0_nb[i];
            bit_pg[i].p = s0_p[i];
        end
        bit_pg[0].g = (s0_a[0] & s0_nb[0]) | (s0_p[0] & s0_cin);
    end

    // ------------------------------------------------------------------
    // S1: even-bit prefix tree (odd indices carry the groups)
    // Level 0 pairs each odd bit with its lower neighbour; later levels are
    // Kogge-Stone over the odd columns with doubling span.
    // ------------------------------------------------------------------
    generate
        for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
            localparam int DIST = 1 << l;
            pg_t prv [WIDTH];
            pg_t nxt [WIDTH];

            if (l == 0) begin : g_src
                assign prv = bit_pg;
            end else begin : g_chain
                assign prv = g_lvl[l-1].nxt;
            end

            for (genvar i = 0; i < WIDTH; i++) begin : g_col
                if ((i % 2) == 1 && i >= DIST) begin : g_cell
                    hc_prefix_cell u_cell (
                        .hi  (prv[i]),
                        .lo  (prv[i-DIST]),
                        .grp (nxt[i])
                    );
                end else begin : g_pass
                    assign nxt[i] = prv[i];
                end
            end
        end
    endgenerate

    assign tree_out = g_lvl[LEVELS-1].nxt;

    // Tree result and the bits still needed by the final stage
    always_ff @(posedge clk) begin
        if (s1_ready && s0_valid) begin
            s1_grp   <= tree_out;
            s1_p     <= s0_p;
            s1_cin   <= s0_cin;
            s1_a_msb <= s0_a[WIDTH-1];
            s1_b_msb <= ~s0_nb[WIDTH-1];
        end
    end

    // ------------------------------------------------------------------
    // S2: odd-bit fix-up (even indices > 0 merge with the finished group below)
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_fix
            if ((i % 2) == 0 && i > 0) begin : g_cell
                hc_prefix_cell u_cell (
                    .hi  (s1_grp[i]),
                    .lo  (s1_grp[i-1]),
                    .grp (s2_full[i])
                );
            end else begin : g_pass
                assign s2_full[i] = s1_grp[i];
            end
        end
    endgenerate

    // Sum bits and flags from the full-prefix carries
    always_comb begin
        carry[0] = s1_cin;
        for (int unsigned i = 1; i < WIDTH; i++) begin
            carry[i] = s2_full[i-1].g;
        end
        sum       = s1_p ^ carry;
        cout      = s2_full[WIDTH-1].g;
        next_bout = ~cout;
        next_ovf  = (s1_a_msb != s1_b_msb) && (sum[WIDTH-1] != s1_a_msb);
        next_zero = (sum == '0);
    end

    // Group propagate terms of the completed prefixes are never consumed
    always_comb begin
        fixup_p_unused = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            fixup_p_unused = fixup_p_unused ^ s2_full[i].p;
        end
    end

    // Output registers: hold while stalled, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            out_diff <= '0;
            out_bout <= 1'b0;
            out_ovf  <= 1'b0;
            out_zero <= 1'b0;
        end else if (s2_ready && s1_valid) begin
            out_diff <= sum;
            out_bout <= next_bout;
            out_ovf  <= next_ovf;
            out_zero <= next_zero;
        end
    end

endmodule

// File: tb/tb_hc_pipelined_subtractor.sv
// Self-checking bench for hc_pipelined_subtractor (WIDTH = 16).
module tb_hc_pipelined_subtractor;

    localparam int unsigned WIDTH = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hc_pipelined_subtractor_if #(.WIDTH(WIDTH)) bus ();

    hc_pipelined_subtractor #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] diff;
        logic        bout;
        logic        ovf;
        logic        zero;
    } res_t;

    res_t sb [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference: plain wide unsigned and signed integer arithmetic
    function automatic res_t model(logic [15:0] a, logic [15:0] b, logic bin);
        res_t        m;
        logic [16:0] wide;
        int          r;
        wide   = {1'b0, a} - {1'b0, b} - {16'd0, bin};
        r      = int'($signed(a)) - int'($signed(b)) - (bin ? 1 : 0);
        m.diff = wide[15:0];
        m.bout = wide[16];
        m.ovf  = (r > 32767) || (r < -32768);
        m.zero = (wide[15:0] == 16'd0);
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b1;
        repeat (3) tick();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
        n_checks++; if (bus.diff !== 16'h0000) begin n_fail++; $display("FAIL reset_diff: got %h expected 0000", bus.diff); end
        n_checks++; if ({bus.bout, bus.ovf, bus.zero} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {bus.bout, bus.ovf, bus.zero}); end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready: got %b expected 1", bus.in_ready); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release_out_valid: got %b expected 0", bus.out_valid); end
        tick();
    endtask

    task automatic test_directed();
        logic [15:0] va [4] = '{16'h00FF, 16'h0000, 16'h8000, 16'h1234};
        logic [15:0] vb [4] = '{16'h0001, 16'h0001, 16'h0001, 16'h1233};
        logic        vc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [15:0] ed [4] = '{16'h00FE, 16'hFFFF, 16'h7FFF, 16'h0000};
        logic [2:0]  ef [4] = '{3'b000, 3'b100, 3'b010, 3'b001};   // {bout, ovf, zero}
        int edges;
        for (int k = 0; k < 4; k++) begin
            bus.out_ready = 1'b1;
            bus.a = va[k]; bus.b = vb[k]; bus.bin = vc[k];
            bus.in_valid = 1'b1;
            @(negedge clk);
            n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL dir%0d_in_ready: got %b expected 1", k, bus.in_ready); end
            tick();
            bus.in_valid = 1'b0;
            edges = 1;
            while (bus.out_valid !== 1'b1 && edges < 10) begin
                tick();
                edges++;
            end
            n_checks++; if (edges !== 3) begin n_fail++; $display("FAIL dir%0d_latency: got %0d edges expected 3", k, edges); end
            n_checks++; if (bus.diff !== ed[k]) begin n_fail++; $display("FAIL dir%0d_diff: got %h expected %h", k, bus.diff, ed[k]); end
            n_checks++; if ({bus.bout, bus.ovf, bus.zero} !== ef[k]) begin n_fail++; $display("FAIL dir%0d_flags: got %b expected %b", k, {bus.bout, bus.ovf, bus.zero}, ef[k]); end
            tick();
            n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL dir%0d_drained: got %b expected 0", k, bus.out_valid); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] oa [6];
        logic [15:0] ob [6];
        logic        oc [6];
        res_t        exp;
        int          acc  = 0;
        int          pops = 0;
        for (int k = 0; k < 6; k++) begin
            oa[k] = 16'($urandom); ob[k] = 16'($urandom); oc[k] = 1'($urandom);
        end
        sb.delete();
        for (int c = 0; c < 30 && pops < 6; c++) begin
            bus.out_ready = (c >= 5);
            bus.in_valid  = (acc < 6);
            if (acc < 6) begin
                bus.a = oa[acc]; bus.b = ob[acc]; bus.bin = oc[acc];
            end
            @(negedge clk);
            if (c == 3 || c == 4) begin
                n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_in_ready c%0d: got %b expected 0", c, bus.in_ready); end
                n_checks++; if (acc !== 3) begin n_fail++; $display("FAIL b2b_accepts c%0d: got %0d expected 3", c, acc); end
                n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_stall_valid c%0d: got %b expected 1", c, bus.out_valid); end
                if (sb.size() > 0) begin
                    n_checks++; if (bus.diff !== sb[0].diff || bus.bout !== sb[0].bout) begin n_fail++; $display("FAIL b2b_stall_hold c%0d: got %h/%b expected %h/%b", c, bus.diff, bus.bout, sb[0].diff, sb[0].bout); end
                end
            end
            if (c >= 5 && c <= 10) begin
                n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_stream c%0d: got out_valid %b expected 1", c, bus.out_valid); end
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++; n_fail++; $display("FAIL b2b_unexpected_result: got %h expected none", bus.diff);
                end else begin
                    exp = sb.pop_front();
                    n_checks++; if ({bus.diff, bus.bout, bus.ovf, bus.zero} !== {exp.diff, exp.bout, exp.ovf, exp.zero}) begin n_fail++; $display("FAIL b2b_result%0d: got %h/%b%b%b expected %h/%b%b%b", pops, bus.diff, bus.bout, bus.ovf, bus.zero, exp.diff, exp.bout, exp.ovf, exp.zero); end
                end
                pops++;
            end
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
                sb.push_back(model(bus.a, bus.b, bus.bin));
                acc++;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        n_checks++; if (pops !== 6) begin n_fail++; $display("FAIL b2b_result_count: got %0d expected 6", pops); end
    endtask

    task automatic test_reset_midflight();
        res_t exp;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a = 16'h5555; bus.b = 16'h1111; bus.bin = 1'b0;
        tick();
        bus.a = 16'hA0A0; bus.b = 16'h0A0A; bus.bin = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready: got %b expected 0", bus.in_ready); end
        tick();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b expected 0", bus.out_valid); end
        n_checks++; if ({bus.diff, bus.bout, bus.ovf, bus.zero} !== 19'd0) begin n_fail++; $display("FAIL midrst_outputs: got %h/%b%b%b expected 0", bus.diff, bus.bout, bus.ovf, bus.zero); end
        rst = 1'b0;
        bus.a = 16'h0100; bus.b = 16'h0020; bus.bin = 1'b1;
        bus.in_valid = 1'b1;
        exp = model(16'h0100, 16'h0020, 1'b1);
        @(negedge clk);
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_release_in_ready: got %b expected 1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        for (int e = 1; e < 3; e++) begin
            n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stale e%0d: got out_valid %b expected 0", e, bus.out_valid); end
            tick();
        end
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_latency: got out_valid %b expected 1", bus.out_valid); end
        n_checks++; if ({bus.diff, bus.bout, bus.ovf, bus.zero} !== {exp.diff, exp.bout, exp.ovf, exp.zero}) begin n_fail++; $display("FAIL midrst_result: got %h/%b%b%b expected %h/%b%b%b", bus.diff, bus.bout, bus.ovf, bus.zero, exp.diff, exp.bout, exp.ovf, exp.zero); end
        tick();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_drained: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_random();
        res_t exp;
        int   acc  = 0;
        int   pops = 0;
        int   cyc  = 0;
        int   sel;
        sb.delete();
        while ((acc < 10000 || pops < acc) && cyc < 80000) begin
            bus.in_valid  = (acc < 10000) && ($urandom_range(0, 99) < 70);
            bus.out_ready = ($urandom_range(0, 99) < 70);
            bus.a   = 16'($urandom);
            bus.b   = 16'($urandom);
            bus.bin = 1'($urandom);
            sel = $urandom_range(0, 7);
            if (sel == 0) bus.b = bus.a;
            else if (sel == 1) bus.a = 16'h0000;
            else if (sel == 2) bus.a = 16'h8000;
            @(negedge clk);
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++; n_fail++; $display("FAIL rnd_unexpected_result: got %h expected none", bus.diff);
                end else begin
                    exp = sb.pop_front();
                    n_checks++; if ({bus.diff, bus.bout, bus.ovf, bus.zero} !== {exp.diff, exp.bout, exp.ovf, exp.zero}) begin n_fail++; $display("FAIL rnd_result%0d: got %h/%b%b%b expected %h/%b%b%b", pops, bus.diff, bus.bout, bus.ovf, bus.zero, exp.diff, exp.bout, exp.ovf, exp.zero); end
                end
                pops++;
            end
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
                sb.push_back(model(bus.a, bus.b, bus.bin));
                acc++;
            end
            tick();
            cyc++;
        end
        bus.in_valid = 1'b0;
        n_checks++; if (acc !== 10000) begin n_fail++; $display("FAIL rnd_accept_count: got %0d expected 10000", acc); end
        n_checks++; if (pops !== acc) begin n_fail++; $display("FAIL rnd_result_count: got %0d expected %0d", pops, acc); end
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
